// File: rtl/ev_multi_slot_charger.sv
// N-slot EV charging controller: per-slot session FSMs with sticky fault codes and
// session timers, plus a round-robin arbiter that admits waiting slots under a budget.
//
// state    | meaning
// IDLE  0  | no session, waiting for a plugged vehicle with sufficient voltage
// WAIT  1  | session requested, queued for the arbiter
// CHARGING | admitted, timer running, faults monitored
// FULL  3  | target voltage reached, timer frozen until unplug
// ERROR 4  | fault latched, needs fault_clear with the fault gone
module ev_multi_slot_charger #(
  parameter int NUM_SLOTS  = 4,
  parameter int DATA_W     = 16,
  parameter int TIME_W     = 32,
  parameter int MAX_ACTIVE = 2,
  parameter int V_START    = 1000,
  parameter int V_FULL     = 4000,
  parameter int V_MAX      = 4500,
  parameter int I_MAX      = 3000,
  parameter int T_MAX      = 80,
  localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int CNT_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SLOTS-1:0]          slot_request,
  input  logic [NUM_SLOTS*DATA_W-1:0]   voltage,
  input  logic [NUM_SLOTS*DATA_W-1:0]   current,
  input  logic [NUM_SLOTS*DATA_W-1:0]   temperature,
  input  logic [NUM_SLOTS-1:0]          fault_clear,
  output logic [NUM_SLOTS-1:0]          charging,
  output logic [NUM_SLOTS*3-1:0]        slot_state,
  output logic [NUM_SLOTS*8-1:0]        fault_code,
  output logic [NUM_SLOTS*TIME_W-1:0]   charging_time,
  output logic [CNT_W-1:0]              active_count,
  output logic                          grant_valid,
  output logic [SLOT_W-1:0]             grant_slot
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_CHG  = 3'd2;
  localparam logic [2:0] S_FULL = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [DATA_W-1:0] V_START_L = DATA_W'(V_START);
  localparam logic [DATA_W-1:0] V_FULL_L  = DATA_W'(V_FULL);
  localparam logic [DATA_W-1:0] V_MAX_L   = DATA_W'(V_MAX);
  localparam logic [DATA_W-1:0] I_MAX_L   = DATA_W'(I_MAX);
  localparam logic [DATA_W-1:0] T_MAX_L   = DATA_W'(T_MAX);
  localparam logic [CNT_W-1:0]  MAX_L     = CNT_W'(MAX_ACTIVE);
  localparam logic [TIME_W-1:0] TIME_SAT  = {TIME_W{1'b1}};

  logic [2:0]        state_q [NUM_SLOTS];
  logic [2:0]        state_d [NUM_SLOTS];
  logic [DATA_W-1:0] v_s     [NUM_SLOTS];
  logic [DATA_W-1:0] i_s     [NUM_SLOTS];
  logic [DATA_W-1:0] t_s     [NUM_SLOTS];
  logic [7:0]        flt     [NUM_SLOTS];
  logic [7:0]        fcode_q [NUM_SLOTS];
  logic [TIME_W-1:0] time_q  [NUM_SLOTS];

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SLOT_W-1:0]    rr_ptr, rr_next;
  logic [SLOT_W-1:0]    grant_idx, cand;
  logic [NUM_SLOTS-1:0] grant_vec;
  logic                 grant_any;
  int                   cidx;

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      v_s[i] = voltage[i*DATA_W +: DATA_W];
      i_s[i] = current[i*DATA_W +: DATA_W];
      t_s[i] = temperature[i*DATA_W +: DATA_W];
      flt[i] = {5'b0, v_s[i] > V_MAX_L, i_s[i] > I_MAX_L, t_s[i] > T_MAX_L};
    end
  end

  // Budget check uses the registered count, so a slot leaving CHARGING frees
  // its place only from the following cycle.
  always_comb begin
    grant_vec = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    cidx      = 0;
    if (cnt_q < MAX_L) begin
      for (int j = 0; j < NUM_SLOTS; j++) begin
        cidx = int'(rr_ptr) + j;
        if (cidx >= NUM_SLOTS) cidx = cidx - NUM_SLOTS;
        cand = SLOT_W'(cidx);
        if (!grant_any && state_q[cand] == S_WAIT && slot_request[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (grant_any) grant_vec[grant_idx] = 1'b1;
  end

  assign rr_next = (grant_idx == SLOT_W'(NUM_SLOTS - 1)) ? '0 : grant_idx + SLOT_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) state_q[i] <= S_IDLE;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) state_q[i] <= state_d[i];
      cnt_q <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        S_IDLE: if (slot_request[i] && v_s[i] > V_START_L) state_d[i] = S_WAIT;
        S_WAIT: begin
          if (!slot_request[i])  state_d[i] = S_IDLE;
          else if (grant_vec[i]) state_d[i] = S_CHG;
        end
        S_CHG: begin
          if (flt[i] != 8'd0)          state_d[i] = S_ERR;
          else if (v_s[i] >= V_FULL_L) state_d[i] = S_FULL;
          else if (!slot_request[i])   state_d[i] = S_IDLE;
        end
        S_FULL: if (!slot_request[i]) state_d[i] = S_IDLE;
        S_ERR:  if (fault_clear[i] && flt[i] == 8'd0) state_d[i] = S_IDLE;
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (state_d[i] == S_CHG) cnt_d = cnt_d + CNT_W'(1);
  end

  // Output decode
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      charging[i]                       = (state_q[i] == S_CHG);
      slot_state[i*3 +: 3]              = state_q[i];
      fault_code[i*8 +: 8]              = fcode_q[i];
      charging_time[i*TIME_W +: TIME_W] = time_q[i];
    end
  end

  assign active_count = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        fcode_q[i] <= 8'd0;
        time_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        case (state_q[i])
          S_WAIT: if (grant_vec[i]) time_q[i] <= '0;
          S_CHG: begin
            if (time_q[i] != TIME_SAT) time_q[i] <= time_q[i] + TIME_W'(1);
            fcode_q[i] <= fcode_q[i] | flt[i];
          end
          S_ERR: begin
            if (fault_clear[i] && flt[i] == 8'd0) fcode_q[i] <= 8'd0;
            else                                  fcode_q[i] <= fcode_q[i] | flt[i];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_valid <= 1'b0;
      grant_slot  <= '0;
      rr_ptr      <= '0;
    end else begin
      grant_valid <= grant_any;
      if (grant_any) begin
        grant_slot <= grant_idx;
        rr_ptr     <= rr_next;
      end
    end
  end

endmodule

// File: tb/tb_ev_multi_slot_charger.sv
// Directed bench for ev_multi_slot_charger: a 4-slot instance for session/arbiter
// behaviour and a 1-slot TIME_W=4 instance for timer saturation.
module tb_ev_multi_slot_charger;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  slot_request, fault_clear;
  logic [63:0] voltage, current, temperature;
  logic [3:0]  charging;
  logic [11:0] slot_state;
  logic [31:0] fault_code;
  logic [127:0] charging_time;
  logic [2:0]  active_count;
  logic        grant_valid;
  logic [1:0]  grant_slot;

  logic        s_req, s_clr;
  logic [15:0] s_v, s_i, s_t;
  logic        s_charging, s_gv;
  logic [2:0]  s_state;
  logic [7:0]  s_fcode;
  logic [3:0]  s_time;
  logic [0:0]  s_active, s_gslot;

  int cmp = 0;
  int errs = 0;

  always #5 clk = ~clk;

  ev_multi_slot_charger #(.NUM_SLOTS(4), .TIME_W(32), .MAX_ACTIVE(2)) dut (
    .clk(clk), .reset(reset), .slot_request(slot_request), .voltage(voltage),
    .current(current), .temperature(temperature), .fault_clear(fault_clear),
    .charging(charging), .slot_state(slot_state), .fault_code(fault_code),
    .charging_time(charging_time), .active_count(active_count),
    .grant_valid(grant_valid), .grant_slot(grant_slot));

  ev_multi_slot_charger #(.NUM_SLOTS(1), .TIME_W(4), .MAX_ACTIVE(1)) dut_sat (
    .clk(clk), .reset(reset), .slot_request(s_req), .voltage(s_v),
    .current(s_i), .temperature(s_t), .fault_clear(s_clr),
    .charging(s_charging), .slot_state(s_state), .fault_code(s_fcode),
    .charging_time(s_time), .active_count(s_active),
    .grant_valid(s_gv), .grant_slot(s_gslot));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic r, input logic [15:0] v,
                          input logic [15:0] c, input logic [15:0] t);
    slot_request[i] = r;
    voltage[i*16 +: 16] = v;
    current[i*16 +: 16] = c;
    temperature[i*16 +: 16] = t;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) set_slot(i, 1'b0, 16'd1500, 16'd100, 16'd25);
    fault_clear = '0;
    s_req = 1'b0; s_v = 16'd1500; s_i = 16'd100; s_t = 16'd25; s_clr = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cmp++; if (slot_state !== 12'h000) begin errs++; $display("FAIL reset_state: got %h want %h", slot_state, 12'h000); end
    cmp++; if (charging !== 4'h0) begin errs++; $display("FAIL reset_charging: got %h want 0", charging); end
    cmp++; if (fault_code !== 32'h0) begin errs++; $display("FAIL reset_fault_code: got %h want 0", fault_code); end
    cmp++; if (charging_time !== 128'h0) begin errs++; $display("FAIL reset_time: got %h want 0", charging_time); end
    cmp++; if (active_count !== 3'd0) begin errs++; $display("FAIL reset_active: got %0d want 0", active_count); end
    cmp++; if (grant_valid !== 1'b0 || grant_slot !== 2'd0) begin errs++; $display("FAIL reset_grant: got %b/%0d want 0/0", grant_valid, grant_slot); end
  endtask

  task automatic test_single_slot();
    do_reset();
    set_slot(0, 1'b1, 16'd1000, 16'd100, 16'd25);
    tick();
    cmp++; if (slot_state[2:0] !== 3'd0) begin errs++; $display("FAIL vstart_boundary: got %0d want 0", slot_state[2:0]); end
    set_slot(0, 1'b1, 16'd1500, 16'd100, 16'd25);
    tick();
    cmp++; if (slot_state[2:0] !== 3'd1 || grant_valid !== 1'b0) begin errs++; $display("FAIL single_wait: got st=%0d gv=%b want 1/0", slot_state[2:0], grant_valid); end
    tick();
    cmp++; if (slot_state[2:0] !== 3'd2 || charging !== 4'b0001) begin errs++; $display("FAIL single_chg: got st=%0d chg=%b want 2/0001", slot_state[2:0], charging); end
    cmp++; if (grant_valid !== 1'b1 || grant_slot !== 2'd0) begin errs++; $display("FAIL single_grant: got %b/%0d want 1/0", grant_valid, grant_slot); end
    cmp++; if (charging_time[31:0] !== 32'd0 || active_count !== 3'd1) begin errs++; $display("FAIL single_start: got t=%0d ac=%0d want 0/1", charging_time[31:0], active_count); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      cmp++; if (charging_time[31:0] !== 32'(k)) begin errs++; $display("FAIL single_count: got %0d want %0d", charging_time[31:0], k); end
    end
    cmp++; if (grant_valid !== 1'b0) begin errs++; $display("FAIL single_gv_pulse: got %b want 0", grant_valid); end
  endtask

  task automatic test_all_slots();
    do_reset();
    for (int i = 0; i < 4; i++) set_slot(i, 1'b1, 16'd1500, 16'd100, 16'd25);
    tick();
    cmp++; if (slot_state !== 12'h249 || active_count !== 3'd0) begin errs++; $display("FAIL all_wait: got %h/%0d want 249/0", slot_state, active_count); end
    tick();
    cmp++; if (grant_valid !== 1'b1 || grant_slot !== 2'd0 || active_count !== 3'd1) begin errs++; $display("FAIL all_grant0: got %b/%0d/%0d want 1/0/1", grant_valid, grant_slot, active_count); end
    tick();
    cmp++; if (grant_valid !== 1'b1 || grant_slot !== 2'd1 || active_count !== 3'd2) begin errs++; $display("FAIL all_grant1: got %b/%0d/%0d want 1/1/2", grant_valid, grant_slot, active_count); end
    tick();
    cmp++; if (grant_valid !== 1'b0 || slot_state !== 12'h252) begin errs++; $display("FAIL all_budget: got gv=%b st=%h want 0/252", grant_valid, slot_state); end
    set_slot(0, 1'b1, 16'd4000, 16'd100, 16'd25);
    tick();
    cmp++; if (slot_state[2:0] !== 3'd3 || active_count !== 3'd1 || grant_valid !== 1'b0) begin errs++; $display("FAIL all_full: got st=%0d ac=%0d gv=%b want 3/1/0", slot_state[2:0], active_count, grant_valid); end
    tick();
    cmp++; if (grant_valid !== 1'b1 || grant_slot !== 2'd2 || active_count !== 3'd2) begin errs++; $display("FAIL all_grant2: got %b/%0d/%0d want 1/2/2", grant_valid, grant_slot, active_count); end
    cmp++; if (slot_state !== 12'h293 || charging !== 4'b0110) begin errs++; $display("FAIL all_final: got %h/%b want 293/0110", slot_state, charging); end
  endtask

  task automatic test_over_temp();
    do_reset();
    set_slot(1, 1'b1, 16'd1500, 16'd100, 16'd25);
    tick();
    tick();
    cmp++; if (slot_state[5:3] !== 3'd2 || grant_slot !== 2'd1) begin errs++; $display("FAIL ot_chg: got st=%0d gs=%0d want 2/1", slot_state[5:3], grant_slot); end
    set_slot(1, 1'b1, 16'd1500, 16'd100, 16'd81);
    tick();
    cmp++; if (slot_state[5:3] !== 3'd4 || fault_code[15:8] !== 8'h01 || charging[1] !== 1'b0) begin errs++; $display("FAIL ot_err: got st=%0d fc=%h chg=%b want 4/01/0", slot_state[5:3], fault_code[15:8], charging[1]); end
    fault_clear[1] = 1'b1;
    tick();
    cmp++; if (slot_state[5:3] !== 3'd4 || fault_code[15:8] !== 8'h01) begin errs++; $display("FAIL ot_clear_blocked: got st=%0d fc=%h want 4/01", slot_state[5:3], fault_code[15:8]); end
    fault_clear[1] = 1'b0;
    set_slot(1, 1'b1, 16'd1500, 16'd3001, 16'd81);
    tick();
    cmp++; if (fault_code[15:8] !== 8'h03) begin errs++; $display("FAIL ot_sticky_or: got %h want 03", fault_code[15:8]); end
    set_slot(1, 1'b1, 16'd1500, 16'd100, 16'd80);
    tick();
    cmp++; if (slot_state[5:3] !== 3'd4 || fault_code[15:8] !== 8'h03) begin errs++; $display("FAIL ot_hold: got st=%0d fc=%h want 4/03", slot_state[5:3], fault_code[15:8]); end
    fault_clear[1] = 1'b1;
    tick();
    cmp++; if (slot_state[5:3] !== 3'd0 || fault_code[15:8] !== 8'h00) begin errs++; $display("FAIL ot_cleared: got st=%0d fc=%h want 0/00", slot_state[5:3], fault_code[15:8]); end
    fault_clear[1] = 1'b0;
  endtask

  task automatic test_multi_fault();
    do_reset();
    set_slot(2, 1'b1, 16'd1500, 16'd100, 16'd25);
    tick();
    tick();
    cmp++; if (slot_state[8:6] !== 3'd2) begin errs++; $display("FAIL mf_chg: got %0d want 2", slot_state[8:6]); end
    set_slot(2, 1'b1, 16'd4600, 16'd3001, 16'd25);
    tick();
    cmp++; if (slot_state[8:6] !== 3'd4 || fault_code[23:16] !== 8'h06) begin errs++; $display("FAIL mf_err: got st=%0d fc=%h want 4/06", slot_state[8:6], fault_code[23:16]); end
  endtask

  task automatic test_drop_request();
    do_reset();
    set_slot(3, 1'b1, 16'd1500, 16'd100, 16'd25);
    tick();
    cmp++; if (slot_state[11:9] !== 3'd1) begin errs++; $display("FAIL drop_wait: got %0d want 1", slot_state[11:9]); end
    slot_request[3] = 1'b0;
    tick();
    cmp++; if (slot_state[11:9] !== 3'd0 || grant_valid !== 1'b0) begin errs++; $display("FAIL drop_wait_idle: got st=%0d gv=%b want 0/0", slot_state[11:9], grant_valid); end
    slot_request[3] = 1'b1;
    tick();
    tick();
    cmp++; if (grant_valid !== 1'b1 || grant_slot !== 2'd3 || slot_state[11:9] !== 3'd2) begin errs++; $display("FAIL drop_grant3: got %b/%0d/%0d want 1/3/2", grant_valid, grant_slot, slot_state[11:9]); end
    tick();
    tick();
    slot_request[3] = 1'b0;
    tick();
    cmp++; if (slot_state[11:9] !== 3'd0 || charging_time[127:96] !== 32'd3) begin errs++; $display("FAIL drop_chg_idle: got st=%0d t=%0d want 0/3", slot_state[11:9], charging_time[127:96]); end
    tick();
    tick();
    cmp++; if (charging_time[127:96] !== 32'd3 || active_count !== 3'd0) begin errs++; $display("FAIL drop_time_hold: got t=%0d ac=%0d want 3/0", charging_time[127:96], active_count); end
  endtask

  task automatic test_saturation();
    do_reset();
    s_req = 1'b1;
    tick();
    tick();
    cmp++; if (s_state !== 3'd2 || s_time !== 4'd0 || s_gv !== 1'b1) begin errs++; $display("FAIL sat_start: got st=%0d t=%0d gv=%b want 2/0/1", s_state, s_time, s_gv); end
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14 || k == 15 || k == 16 || k == 20) begin
        cmp++; if (s_time !== ((k > 15) ? 4'd15 : 4'(k))) begin errs++; $display("FAIL sat_count: cycle %0d got %0d want %0d", k, s_time, (k > 15) ? 15 : k); end
      end
    end
    cmp++; if (s_state !== 3'd2 || s_charging !== 1'b1) begin errs++; $display("FAIL sat_still_chg: got %0d/%b want 2/1", s_state, s_charging); end
  endtask

  task automatic test_reset_mid_session();
    do_reset();
    set_slot(0, 1'b1, 16'd1500, 16'd100, 16'd25);
    set_slot(1, 1'b1, 16'd1500, 16'd100, 16'd25);
    s_req = 1'b1;
    tick();
    tick();
    tick();
    tick();
    set_slot(1, 1'b1, 16'd1500, 16'd100, 16'd81);
    tick();
    cmp++; if (slot_state[5:0] !== 6'o42 || fault_code[15:8] !== 8'h01 || grant_slot !== 2'd1) begin errs++; $display("FAIL mid_setup: got st=%o fc=%h gs=%0d want 42/01/1", slot_state[5:0], fault_code[15:8], grant_slot); end
    reset = 1'b1;
    tick();
    cmp++; if (slot_state !== 12'h0 || charging !== 4'h0 || fault_code !== 32'h0 || charging_time !== 128'h0) begin errs++; $display("FAIL mid_reset_slots: got st=%h chg=%h fc=%h t=%h want all 0", slot_state, charging, fault_code, charging_time); end
    cmp++; if (active_count !== 3'd0 || grant_valid !== 1'b0 || grant_slot !== 2'd0) begin errs++; $display("FAIL mid_reset_arb: got %0d/%b/%0d want 0/0/0", active_count, grant_valid, grant_slot); end
    cmp++; if (s_state !== 3'd0 || s_time !== 4'd0 || s_active !== 1'b0) begin errs++; $display("FAIL mid_reset_sat: got %0d/%0d/%0d want 0/0/0", s_state, s_time, s_active); end
    reset = 1'b0;
    tick();
    cmp++; if (slot_state[2:0] !== 3'd1) begin errs++; $display("FAIL mid_restart: got %0d want 1", slot_state[2:0]); end
  endtask

  initial begin
    reset = 1'b1;
    slot_request = '0; fault_clear = '0;
    voltage = '0; current = '0; temperature = '0;
    s_req = 1'b0; s_clr = 1'b0; s_v = '0; s_i = '0; s_t = '0;
    test_reset();
    test_single_slot();
    test_all_slots();
    test_over_temp();
    test_multi_fault();
    test_drop_request();
    test_saturation();
    test_reset_mid_session();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
